// File: rtl/nios2_mult_pipe_if.sv
// Issue/result handshake bundle between the operand muxes, the multiplier and writeback.
// The master drives operations and consumes results; the slave is the multiplier.
interface nios2_mult_pipe_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_op;
   logic [DATA_W-1:0] in_src1;
   logic [DATA_W-1:0] in_src2;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [TAG_W-1:0]  out_tag;

   modport master (
      output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/nios2_mult_pipe.sv
// Pipelined MUL/MULXSS/MULXSU/MULXUU unit: stage 1 forms four partial products,
// the next stage sums them and selects the word, later stages only delay the result.
module nios2_mult_pipe #(
   parameter int DATA_W = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   nios2_mult_pipe_if.slave   bus,
   output logic               busy
);
   localparam int EXT_W  = DATA_W + 1;
   localparam int PROD_W = 2 * DATA_W + 2;
   localparam int PART_W = DATA_W / 2;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULXSS = 2'b01,
      OP_MULXSU = 2'b10,
      OP_MULXUU = 2'b11
   } op_e;

   typedef struct packed {
      logic [PROD_W-1:0] ll;
      logic [PROD_W-1:0] lh;
      logic [PROD_W-1:0] hl;
      logic [PROD_W-1:0] hh;
   } pp_t;

   // Low halves are unsigned, high halves carry the extension bit and are signed,
   // so the four products sum modulo 2^PROD_W to the exact signed product.
   function automatic pp_t form_pp(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
      logic                     sa, sb;
      logic [EXT_W-1:0]         ax, bx;
      logic signed [PROD_W-1:0] a_lo, a_hi, b_lo, b_hi;
      pp_t                      pp;
      sa   = (op == OP_MULXSS) || (op == OP_MULXSU);
      sb   = (op == OP_MULXSS);
      ax   = {sa & a[DATA_W-1], a};
      bx   = {sb & b[DATA_W-1], b};
      a_lo = PROD_W'(ax[PART_W-1:0]);
      b_lo = PROD_W'(bx[PART_W-1:0]);
      a_hi = PROD_W'($signed(ax[EXT_W-1:PART_W]));
      b_hi = PROD_W'($signed(bx[EXT_W-1:PART_W]));
      pp.ll = a_lo * b_lo;
      pp.lh = a_lo * b_hi;
      pp.hl = a_hi * b_lo;
      pp.hh = a_hi * b_hi;
      return pp;
   endfunction

   function automatic logic [DATA_W-1:0] pick_word(input pp_t pp, input logic [1:0] op);
      logic [PROD_W-1:0] prod;
      prod = pp.ll + (pp.lh << PART_W) + (pp.hl << PART_W) + (pp.hh << (2 * PART_W));
      return (op == OP_MUL) ? DATA_W'(prod) : DATA_W'(prod >> DATA_W);
   endfunction

   logic [STAGES-1:0] stage_valid;
   logic [TAG_W-1:0]  stage_tag [STAGES];
   logic [DATA_W-1:0] out_word;
   logic              stall;
   logic              advance;

   assign stall          = stage_valid[STAGES-1] && !bus.out_ready;
   assign advance        = !stall;
   assign bus.in_ready   = advance;
   assign bus.out_valid  = stage_valid[STAGES-1];
   assign bus.out_tag    = stage_tag[STAGES-1];
   assign bus.out_result = out_word;
   assign busy           = |stage_valid;

   // NOTE: non-blocking assignments, so each stage samples its predecessor's pre-edge value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_valid <= '0;
         for (int k = 0; k < STAGES; k++) stage_tag[k] <= '0;
      end else begin
         if (flush) begin
            stage_valid <= '0;
         end else if (advance) begin
            stage_valid[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) stage_valid[k] <= stage_valid[k-1];
         end
         if (advance) begin
            stage_tag[0] <= bus.in_tag;
            for (int k = 1; k < STAGES; k++) stage_tag[k] <= stage_tag[k-1];
         end
      end
   end

   if (STAGES == 1) begin : g_single
      // NOTE: datapath registers are reset as well, so out_result reads zero straight after reset.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            out_word <= '0;
         end else if (advance) begin
            out_word <= pick_word(form_pp(bus.in_op, bus.in_src1, bus.in_src2), bus.in_op);
         end
      end
   end else begin : g_multi
      pp_t               pp_r;
      logic [1:0]        op_r;
      logic [DATA_W-1:0] res_r [STAGES-1];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pp_r <= '0;
            op_r <= '0;
         end else if (advance) begin
            pp_r <= form_pp(bus.in_op, bus.in_src1, bus.in_src2);
            op_r <= bus.in_op;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k < STAGES - 1; k++) res_r[k] <= '0;
         end else if (advance) begin
            res_r[0] <= pick_word(pp_r, op_r);
            for (int k = 1; k < STAGES - 1; k++) res_r[k] <= res_r[k-1];
         end
      end

      assign out_word = res_r[STAGES-2];
   end
endmodule
